// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder with word RAM and an I/O page
// holding a 64-bit cycle counter, a byte output FIFO and sticky status flags.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          OUT_DEPTH   = 8,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_en,
  input  logic        mem_wr,
  output logic [31:0] mem_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        dmem_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(OUT_DEPTH);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [7:0]    fifo [OUT_DEPTH];
  logic [63:0]   cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d, bad_q, bad_d;
  logic          ram_sel, io_sel, rd, wr, empty, full, pop, push_req, push, w1c;
  logic [5:0]    off;
  logic [31:0]   status;
  logic          unused_ok;

  assign ram_sel   = (mem_addr >> (AW + 2)) == 32'd0;
  assign io_sel    = !ram_sel && mem_addr[31:8] == IO_BASE[31:8];
  assign off       = mem_addr[7:2];
  assign rd        = mem_en && !mem_wr;
  assign wr        = mem_en && mem_wr;
  assign empty     = count_q == '0;
  assign full      = count_q == (PW+1)'(OUT_DEPTH);
  assign pop       = !empty && out_ready;
  assign push_req  = wr && io_sel && off == 6'd2;
  assign push      = push_req && (!full || pop);
  assign w1c       = wr && io_sel && off == 6'd3;
  assign status    = {16'd0, 8'(count_q), 4'd0, bad_q, ovf_q, full, empty};
  assign out_valid = !empty;
  assign out_data  = empty ? 8'd0 : fifo[rptr_q];
  assign dmem_err  = bad_q;
  assign unused_ok = ^mem_addr[1:0];

  assign mem_rdata = !rd               ? 32'd0 :
                     ram_sel           ? ram[mem_addr[AW+1:2]] :
                     !io_sel           ? 32'd0 :
                     off == 6'd0       ? cnt_q[31:0] :
                     off == 6'd1       ? hi_q :
                     off == 6'd3       ? status : 32'd0;

  always_comb begin
    cnt_d   = (wr && io_sel && off == 6'd0) ? 64'd0 : cnt_q + 64'd1;
    hi_d    = (rd && io_sel && off == 6'd0) ? cnt_q[63:32] : hi_q;
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d   = (push_req && !push) || (ovf_q && !(w1c && mem_wdata[2]));
    bad_d   = (mem_en && !ram_sel && !io_sel) || (bad_q && !(w1c && mem_wdata[3]));
  end

  // RAM and FIFO storage are not cleared; holding them in reset drops in-flight stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      if (wr && ram_sel) ram[mem_addr[AW+1:2]] <= mem_wdata;
      if (push) fifo[wptr_q] <= mem_wdata[7:0];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with expected loads and console bytes queued
// for a negedge monitor that compares them as the DUT presents them.
module tb_dmem_responder;
  localparam logic [31:0] IO = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, out_valid, out_ready, dmem_err;
  logic [7:0]  out_data;

  logic [31:0] ld_q[$];
  logic [7:0]  out_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  dmem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask

  task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    mem_en = 1'b1;
    mem_wr = w;
    mem_addr = a;
    mem_wdata = d;
    if (!w) ld_q.push_back(e);
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) out_q.push_back(b);
    acc(1'b1, IO + 32'h8, {24'd0, b}, 32'd0);
  endtask

  // Monitor: every load pops its expected value; any other cycle must read 0.
  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      if (ld_q.size() == 0) cmp("load_unexpected", mem_rdata, 32'hXXXX_XXXX);
      else cmp("load", mem_rdata, ld_q.pop_front());
    end else cmp("rdata_zero", mem_rdata, 32'd0);
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) cmp("out_unexpected", {24'd0, out_data}, 32'hXXXX_XXXX);
      else cmp("out_byte", {24'd0, out_data}, {24'd0, out_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; out_ready = 1'b0;
    idle(3);
    cmp("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_out_data", {24'd0, out_data}, 32'd0);
    cmp("rst_dmem_err", {31'd0, dmem_err}, 32'd0);
    rst_n = 1'b1;
    acc(1'b0, IO, 0, 32'd0);
    acc(1'b0, IO + 32'hC, 0, 32'h1);
    acc(1'b0, IO + 32'h4, 0, 32'd0);
    idle(2);
    acc(1'b0, IO, 0, 32'd5);
    acc(1'b1, IO, 32'h1234, 0);
    acc(1'b0, IO, 0, 32'd0);
    acc(1'b0, IO, 0, 32'd1);
    acc(1'b1, 32'h14, 32'd0, 0);
    acc(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    acc(1'b0, 32'h10, 0, 32'hDEAD_BEEF);
    acc(1'b0, 32'h13, 0, 32'hDEAD_BEEF);
    acc(1'b0, 32'h14, 0, 32'd0);
    force dut.cnt_q = 64'h0000_0001_FFFF_FFFE;
    acc(1'b0, IO, 0, 32'hFFFF_FFFE);
    release dut.cnt_q;
    acc(1'b0, IO + 32'h4, 0, 32'h1);
    acc(1'b1, IO, 32'd0, 0);
    for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i), 1'b1);
    acc(1'b0, IO + 32'hC, 0, 32'h0802);
    push_byte(8'h49, 1'b0);
    acc(1'b0, IO + 32'hC, 0, 32'h0806);
    cmp("ovf_err_unchanged", {31'd0, dmem_err}, 32'd0);
    acc(1'b1, IO + 32'hC, 32'h4, 0);
    acc(1'b0, IO + 32'hC, 0, 32'h0802);
    out_ready = 1'b1;
    push_byte(8'h50, 1'b1);
    out_ready = 1'b0;
    acc(1'b0, IO + 32'hC, 0, 32'h0802);
    out_ready = 1'b1;
    idle(8);
    out_ready = 1'b0;
    cmp("drained_valid", {31'd0, out_valid}, 32'd0);
    cmp("drained_data", {24'd0, out_data}, 32'd0);
    acc(1'b0, IO + 32'hC, 0, 32'h1);
    acc(1'b0, 32'h8000_0000, 0, 32'd0);
    cmp("bad_addr_err", {31'd0, dmem_err}, 32'd1);
    acc(1'b0, IO + 32'h40, 0, 32'd0);
    cmp("reserved_err", {31'd0, dmem_err}, 32'd1);
    acc(1'b0, IO + 32'hC, 0, 32'h9);
    acc(1'b1, IO + 32'hC, 32'h8, 0);
    cmp("w1c_err", {31'd0, dmem_err}, 32'd0);
    acc(1'b1, 32'h20, 32'h1234_5678, 0);
    for (int i = 0; i < 3; i++) push_byte(8'h61 + 8'(i), 1'b1);
    out_ready = 1'b1;
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_valid", {31'd0, out_valid}, 32'd0);
    cmp("async_rst_data", {24'd0, out_data}, 32'd0);
    out_ready = 1'b0;
    mem_en = 1'b1; mem_wr = 1'b0; mem_addr = IO;
    ld_q.push_back(32'd0);
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    out_q.delete();
    rst_n = 1'b1;
    acc(1'b0, 32'h20, 0, 32'h1234_5678);
    idle(2);
    cmp("ld_q_left", ld_q.size(), 32'd0);
    cmp("out_q_left", out_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
